// File: rtl/branch_tag_ctrl_pkg.sv
// Shared types for the branch tag controller: tag count, mask/address types,
// the resolve task encoding and a one-hot test helper.
package branch_tag_ctrl_pkg;

    localparam int NUM_BR = 4;
    localparam int ADDR_W = 32;

    typedef logic [NUM_BR-1:0] br_mask_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } br_task_e;

    // True when exactly one bit of m is set.
    function automatic logic is_onehot(input br_mask_t m);
        return (m != '0) && ((m & (m - br_mask_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/branch_tag_ctrl_if.sv
// Dispatch, resolve and broadcast signals of the branch tag controller.
// master = dispatch/branch-FU side, slave = the controller.
interface branch_tag_ctrl_if;
    import branch_tag_ctrl_pkg::*;

    logic     alloc_req;
    logic     alloc_grant;
    br_mask_t alloc_b_id;
    br_mask_t cur_b_mask;
    logic     full;
    br_task_e fu_br_task;
    br_mask_t fu_b_id;
    addr_t    fu_target;
    br_task_e rem_br_task;
    br_mask_t rem_b_id;
    logic     redirect_valid;
    addr_t    redirect_pc;

    modport master (
        output alloc_req, fu_br_task, fu_b_id, fu_target,
        input  alloc_grant, alloc_b_id, cur_b_mask, full,
               rem_br_task, rem_b_id, redirect_valid, redirect_pc
    );

    modport slave (
        input  alloc_req, fu_br_task, fu_b_id, fu_target,
        output alloc_grant, alloc_b_id, cur_b_mask, full,
               rem_br_task, rem_b_id, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_tag_ctrl_lsb_onehot_sel.sv
// Isolates the lowest set bit of req_i (req & -req); used to pick the
// lowest-index free branch tag.
module lsb_onehot_sel #(
    parameter int W = 4
) (
    input  logic [W-1:0] req_i,
    output logic [W-1:0] gnt_o
);

    assign gnt_o = req_i & (-req_i);

endmodule

// File: rtl/branch_tag_ctrl.sv
// Branch tag controller: allocates one-hot branch tags to dispatch, tracks the
// mask of older in-flight branches per tag, and rebroadcasts branch
// resolutions (CLEAR/SQUASH) one cycle later with a fetch redirect on SQUASH.
// Optional macro BR_TAG_CHECK_EN adds err_sticky_o and assertions.
module branch_tag_ctrl
    import branch_tag_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    branch_tag_ctrl_if.slave      bif
`ifdef BR_TAG_CHECK_EN
    ,
    output logic                  err_sticky_o
`endif
);

    logic [NUM_BR-1:0] free_q, free_d;
    br_mask_t          dep_q [NUM_BR];
    br_mask_t          dep_d [NUM_BR];

    br_task_e          rem_task_q;
    br_mask_t          rem_b_id_q;
    logic              redirect_valid_q;
    addr_t             redirect_pc_q;

    logic              fu_active, fu_onehot, fu_live, fu_valid;
    logic              do_clear, do_squash;
    br_mask_t          squash_set, cur_mask, sel_gnt;
    logic              grant;

    // Resolve qualification: a task only acts on a live, one-hot tag.
    assign fu_active = (bif.fu_br_task != NOTHING);
    assign fu_onehot = is_onehot(bif.fu_b_id);
    assign fu_live   = ((bif.fu_b_id & ~free_q) != '0);
    assign fu_valid  = fu_active & fu_onehot & fu_live;
    assign do_clear  = fu_valid & (bif.fu_br_task == CLEAR);
    assign do_squash = fu_valid & (bif.fu_br_task == SQUASH);

    // A squash kills the resolved tag plus every tag that was allocated while it was live.
    generate
        for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_sq
            assign squash_set[gi] = bif.fu_b_id[gi] | (|(dep_q[gi] & bif.fu_b_id));
        end
    endgenerate

    // Pick from the pre-resolution free set so a tag freed this cycle waits one cycle.
    lsb_onehot_sel #(.W(NUM_BR)) u_sel (
        .req_i (free_q),
        .gnt_o (sel_gnt)
    );

    assign cur_mask = ~free_q & ~(fu_active ? bif.fu_b_id : '0);
    assign grant    = bif.alloc_req & (|free_q) & ~do_squash;

    assign bif.alloc_grant    = grant;
    assign bif.alloc_b_id     = grant ? sel_gnt : '0;
    assign bif.cur_b_mask     = cur_mask;
    assign bif.full           = (free_q == '0);
    assign bif.rem_br_task    = rem_task_q;
    assign bif.rem_b_id       = rem_b_id_q;
    assign bif.redirect_valid = redirect_valid_q;
    assign bif.redirect_pc    = redirect_pc_q;

    // Next tag state: apply the resolution first, then the allocation.
    always_comb begin
        free_d = free_q;
        for (int i = 0; i < NUM_BR; i++) dep_d[i] = dep_q[i];
        if (do_clear) begin
            free_d = free_d | bif.fu_b_id;
            for (int i = 0; i < NUM_BR; i++) dep_d[i] = dep_q[i] & ~bif.fu_b_id;
        end
        if (do_squash) begin
            free_d = free_d | squash_set;
            for (int i = 0; i < NUM_BR; i++) if (squash_set[i]) dep_d[i] = '0;
        end
        if (grant) begin
            free_d = free_d & ~sel_gnt;
            for (int i = 0; i < NUM_BR; i++) if (sel_gnt[i]) dep_d[i] = cur_mask;
        end
    end

    // Tag state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q <= '1;
            for (int i = 0; i < NUM_BR; i++) dep_q[i] <= '0;
        end else begin
            free_q <= free_d;
            for (int i = 0; i < NUM_BR; i++) dep_q[i] <= dep_d[i];
        end
    end

    // One-cycle rebroadcast of the resolution and fetch redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_task_q       <= NOTHING;
            rem_b_id_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            rem_task_q       <= fu_valid ? bif.fu_br_task : NOTHING;
            rem_b_id_q       <= fu_valid ? bif.fu_b_id : '0;
            redirect_valid_q <= do_squash;
            if (do_squash) redirect_pc_q <= bif.fu_target;
        end
    end

`ifdef BR_TAG_CHECK_EN
    logic              err_q;
    logic [NUM_BR-1:0] self_dep;
    logic              bad_fu, bad_alloc;

    generate
        for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_self
            assign self_dep[gi] = dep_q[gi][gi];
        end
    endgenerate

    assign bad_fu    = fu_active & ~(fu_onehot & fu_live);
    assign bad_alloc = grant & ~is_onehot(bif.alloc_b_id);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  err_q <= 1'b0;
        else if (bad_fu | bad_alloc | (|self_dep))   err_q <= 1'b1;
    end

    assign err_sticky_o = err_q;

    a_fu_id:    assert property (@(posedge clk) disable iff (!rst_n) !bad_fu);
    a_alloc_id: assert property (@(posedge clk) disable iff (!rst_n) !bad_alloc);
    a_self_dep: assert property (@(posedge clk) disable iff (!rst_n) self_dep == '0);
`endif

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Self-checking bench for branch_tag_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// age-ordered queue model of the live branches.
module tb_branch_tag_ctrl;
    import branch_tag_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    branch_tag_ctrl_if bif ();

    branch_tag_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Live tags in allocation (program) order. A branch depends on exactly the
    // older branches still live when it was allocated, so a squash removes the
    // tag and everything behind it, and a clear removes only the tag.
    int       live_q[$];
    br_task_e exp_task;
    br_mask_t exp_rid;
    logic     exp_rv;
    addr_t    exp_pc;

    function automatic int find_live(input int idx);
        for (int k = 0; k < live_q.size(); k++) if (live_q[k] == idx) return k;
        return -1;
    endfunction

    function automatic int onehot_index(input br_mask_t m);
        int cnt = 0;
        int pos = -1;
        for (int i = 0; i < NUM_BR; i++) if (m[i]) begin cnt++; pos = i; end
        return (cnt == 1) ? pos : -1;
    endfunction

    // Compare process: checks all outputs at the negedge, then advances the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            live_q.delete();
            exp_task = NOTHING;
            exp_rid  = '0;
            exp_rv   = 1'b0;
            exp_pc   = '0;
            chk("rst_rem_task", bif.rem_br_task, NOTHING);
            chk("rst_rem_id", bif.rem_b_id, 0);
            chk("rst_redir_v", bif.redirect_valid, 0);
            chk("rst_redir_pc", bif.redirect_pc, 0);
            chk("rst_full", bif.full, 0);
            chk("rst_cur_mask", bif.cur_b_mask, 0);
        end else begin
            br_task_e t;
            br_mask_t id;
            br_mask_t live_m, cur_m, gid_m;
            int       x, pos, gid;
            logic     valid, sq, g;
            t  = bif.fu_br_task;
            id = bif.fu_b_id;
            x  = onehot_index(id);
            pos = (x >= 0) ? find_live(x) : -1;
            valid = (t != NOTHING) && (pos >= 0);
            sq = valid && (t == SQUASH);
            live_m = '0;
            foreach (live_q[k]) live_m[live_q[k]] = 1'b1;
            cur_m = live_m & ~((t != NOTHING) ? id : br_mask_t'(0));
            g = bif.alloc_req && (live_q.size() < NUM_BR) && !sq;
            gid = -1;
            for (int i = NUM_BR - 1; i >= 0; i--) if (find_live(i) < 0) gid = i;
            gid_m = '0;
            if (g) gid_m[gid] = 1'b1;

            chk("alloc_grant", bif.alloc_grant, g);
            chk("alloc_b_id", bif.alloc_b_id, gid_m);
            chk("cur_b_mask", bif.cur_b_mask, cur_m);
            chk("full", bif.full, live_q.size() == NUM_BR);
            chk("rem_br_task", bif.rem_br_task, exp_task);
            chk("rem_b_id", bif.rem_b_id, exp_rid);
            chk("redirect_valid", bif.redirect_valid, exp_rv);
            chk("redirect_pc", bif.redirect_pc, exp_pc);
            $display("cyc t=%0t req=%0b task=%0d id=%b -> grant=%0b gid=%b mask=%b live=%0d",
                     $time, bif.alloc_req, t, id, bif.alloc_grant, bif.alloc_b_id,
                     bif.cur_b_mask, live_q.size());

            if (valid) begin
                if (t == CLEAR) live_q.delete(pos);
                else while (live_q.size() > pos) void'(live_q.pop_back());
                exp_task = t;
                exp_rid  = id;
                exp_rv   = sq;
                if (sq) exp_pc = bif.fu_target;
            end else begin
                exp_task = NOTHING;
                exp_rid  = '0;
                exp_rv   = 1'b0;
            end
            if (g) live_q.push_back(gid);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic req, input br_task_e t, input br_mask_t id, input addr_t tgt);
        bif.alloc_req  = req;
        bif.fu_br_task = t;
        bif.fu_b_id    = id;
        bif.fu_target  = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_chk(input string nm, input br_mask_t id, input br_mask_t mask);
        drive(1'b1, NOTHING, '0, '0);
        #1;
        chk({nm, "_grant"}, bif.alloc_grant, 1);
        chk({nm, "_id"}, bif.alloc_b_id, id);
        chk({nm, "_mask"}, bif.cur_b_mask, mask);
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, NOTHING, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Fill all four tags; fifth request must stall.
        alloc_chk("fill0", 4'b0001, 4'b0000);
        alloc_chk("fill1", 4'b0010, 4'b0001);
        alloc_chk("fill2", 4'b0100, 4'b0011);
        alloc_chk("fill3", 4'b1000, 4'b0111);
        drive(1'b1, NOTHING, '0, '0);
        #1;
        chk("fill4_grant", bif.alloc_grant, 0);
        chk("fill4_full", bif.full, 1);
        step();

        // CLEAR while full, then reallocate the freed tag.
        drive(1'b0, CLEAR, 4'b0010, '0);
        step();
        chk("clr_rem_task", bif.rem_br_task, CLEAR);
        chk("clr_rem_id", bif.rem_b_id, 4'b0010);
        chk("clr_full", bif.full, 0);
        alloc_chk("clr_realloc", 4'b0010, 4'b1101);

        // SQUASH the oldest tag while full: everything is freed.
        drive(1'b0, SQUASH, 4'b0001, 32'h1040);
        step();
        chk("sq_rem_task", bif.rem_br_task, SQUASH);
        chk("sq_rem_id", bif.rem_b_id, 4'b0001);
        chk("sq_redir_v", bif.redirect_valid, 1);
        chk("sq_redir_pc", bif.redirect_pc, 32'h1040);
        alloc_chk("sq_after", 4'b0001, 4'b0000);

        // SQUASH 0100 with a same-cycle alloc request.
        alloc_chk("s5a", 4'b0010, 4'b0001);
        alloc_chk("s5b", 4'b0100, 4'b0011);
        alloc_chk("s5c", 4'b1000, 4'b0111);
        drive(1'b1, SQUASH, 4'b0100, 32'h2000);
        #1;
        chk("s5_grant", bif.alloc_grant, 0);
        step();
        drive(1'b0, NOTHING, '0, '0);
        #1;
        chk("s5_live", bif.cur_b_mask, 4'b0011);
        step();

        // CLEAR 0001 with a same-cycle alloc request.
        drive(1'b1, CLEAR, 4'b0001, '0);
        #1;
        chk("c6_grant", bif.alloc_grant, 1);
        chk("c6_id", bif.alloc_b_id, 4'b0100);
        chk("c6_mask", bif.cur_b_mask, 4'b0010);
        step();
        alloc_chk("c6_next", 4'b0001, 4'b0110);
        drive(1'b0, NOTHING, '0, '0);

        // Asynchronous reset with three tags live.
        rst_n = 1'b0;
        #1;
        chk("ar_full", bif.full, 0);
        chk("ar_rem_task", bif.rem_br_task, NOTHING);
        chk("ar_redir_v", bif.redirect_valid, 0);
        step();
        rst_n = 1'b1;
        alloc_chk("ar0", 4'b0001, 4'b0000);
        alloc_chk("ar1", 4'b0010, 4'b0001);
        alloc_chk("ar2", 4'b0100, 4'b0011);
        alloc_chk("ar3", 4'b1000, 4'b0111);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            logic     req;
            br_task_e t;
            br_mask_t id;
            int       r, k;
            req = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            t = (r < 5) ? NOTHING : ((r < 8) ? CLEAR : SQUASH);
            k = $urandom_range(0, 15);
            if (k < 13) id = br_mask_t'(1 << (k % NUM_BR));
            else if (k == 13) id = '0;
            else begin
                id  = br_mask_t'($urandom_range(0, 15)) | 4'b0011;
                req = 1'b0;
            end
            drive(req, t, id, addr_t'($urandom));
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            step();
        end
        rst_n = 1'b1;
        drive(1'b0, NOTHING, '0, '0);
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
